// File: rtl/core_define.sv
// Shared core definitions: opcode classes, immediate extraction and reset defaults.
// Used by the fetch stage for static prediction and by decode for operand formation.
package core_define;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // Major opcode field, instruction bits [6:2].
   localparam logic [4:0] ISTR_J  = 5'b11011;
   localparam logic [4:0] ISTR_BR = 5'b11000;

   function automatic logic [31:0] imm_j(input logic [31:0] istr);
      return {{12{istr[31]}}, istr[19:12], istr[20], istr[30:21], 1'b0};
   endfunction

   function automatic logic [31:0] imm_b(input logic [31:0] istr);
      return {{20{istr[31]}}, istr[7], istr[30:25], istr[11:8], 1'b0};
   endfunction

endpackage

// File: rtl/core_if_fifo.sv
// Small synchronous FIFO with flush; head is read straight from the storage registers.
// Depth must be a power of two so the pointers wrap naturally.
module core_if_fifo #(
   parameter int unsigned Width = 32,
   parameter int unsigned Depth = 2,
   localparam int unsigned Aw = (Depth > 1) ? $clog2(Depth) : 1,
   localparam int unsigned Cw = Aw + 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [Width-1:0] data_i,
   input  logic             pop_i,
   output logic [Width-1:0] head_o,
   output logic [Cw-1:0]    count_o
);

   logic [Width-1:0] mem_q [Depth];
   logic [Aw-1:0]    wr_q, rd_q;
   logic [Cw-1:0]    cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (push_i && !pop_i) begin
         cnt_d = cnt_q + Cw'(1);
      end else if (pop_i && !push_i) begin
         cnt_d = cnt_q - Cw'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_i) wr_q <= wr_q + Aw'(1);
         if (pop_i)  rd_q <= rd_q + Aw'(1);
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_i && !rst_i && !flush_i) begin
         mem_q[wr_q] <= data_i;
      end
   end

   assign head_o  = mem_q[rd_q];
   assign count_o = cnt_q;

endmodule

// File: rtl/core_if.sv
// Instruction-fetch stage: credit-limited in-order fetch, static branch prediction,
// instruction buffer towards decode, and wrong-path squashing on flush or predicted jump.
module core_if
   import core_define::*;
#(
   parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rest,
   output logic        ib_req_valid,
   input  logic        ib_req_ready,
   output logic [31:0] ib_req_addr,
   input  logic        ib_resp_valid,
   input  logic [31:0] ib_resp_data,
   input  logic        ex_flush_en,
   input  logic [31:0] ex_flush_pc,
   output logic        fd_valid,
   input  logic        fd_ready,
   output logic [31:0] fd_istr,
   output logic [31:0] fd_pc,
   output logic        fd_jump
);

   localparam int unsigned Cw      = $clog2(FIFO_DEPTH) + 1;
   localparam logic [Cw:0] Credits = (Cw + 1)'(FIFO_DEPTH);

   logic [31:0]   pc_q, pc_d;
   logic [Cw-1:0] drop_q, drop_d;
   logic [Cw-1:0] tag_cnt, ifq_cnt;
   logic [31:0]   tag_pc;
   logic [64:0]   ifq_head;
   logic          accept, keep, pred, fd_pop;
   logic [31:0]   target;
   logic          unused_flush_lo;

   assign unused_flush_lo = ^ex_flush_pc[1:0];

   // The tag FIFO holds one PC per outstanding request, so its count is the outstanding count.
   assign ib_req_valid = !rest && !ex_flush_en && (({1'b0, tag_cnt} + {1'b0, ifq_cnt}) < Credits);
   assign ib_req_addr  = pc_q;
   assign accept       = ib_req_valid && ib_req_ready;
   assign keep         = ib_resp_valid && (drop_q == '0) && !ex_flush_en;

   always_comb begin
      logic is_jal, is_br;
      is_jal = ib_resp_data[6:2] == ISTR_J;
      is_br  = (ib_resp_data[6:2] == ISTR_BR) && ib_resp_data[31];
      pred   = is_jal || is_br;
      target = tag_pc + (is_jal ? imm_j(ib_resp_data) : imm_b(ib_resp_data));
   end

   always_comb begin
      pc_d   = pc_q;
      drop_d = drop_q;
      if (ex_flush_en) begin
         pc_d   = {ex_flush_pc[31:2], 2'b00};
         drop_d = (ib_resp_valid && tag_cnt != '0) ? tag_cnt - Cw'(1) : tag_cnt;
      end else if (keep && pred) begin
         // Everything still in flight, including a request accepted now, is wrong-path.
         pc_d   = target;
         drop_d = tag_cnt - Cw'(1) + Cw'(accept);
      end else begin
         if (accept) pc_d = pc_q + 32'd4;
         if (ib_resp_valid && drop_q != '0) drop_d = drop_q - Cw'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rest) begin
         pc_q   <= RESET_PC;
         drop_q <= '0;
      end else begin
         pc_q   <= pc_d;
         drop_q <= drop_d;
      end
   end

   core_if_fifo #(
      .Width(32),
      .Depth(FIFO_DEPTH)
   ) u_tagq (
      .clk_i  (clk),
      .rst_i  (rest),
      .flush_i(1'b0),
      .push_i (accept),
      .data_i (pc_q),
      .pop_i  (ib_resp_valid),
      .head_o (tag_pc),
      .count_o(tag_cnt)
   );

   core_if_fifo #(
      .Width(65),
      .Depth(FIFO_DEPTH)
   ) u_ifq (
      .clk_i  (clk),
      .rst_i  (rest),
      .flush_i(ex_flush_en),
      .push_i (keep),
      .data_i ({ib_resp_data, tag_pc, pred}),
      .pop_i  (fd_pop),
      .head_o (ifq_head),
      .count_o(ifq_cnt)
   );

   assign fd_valid = ifq_cnt != '0;
   assign fd_pop   = fd_valid && fd_ready;
   assign {fd_istr, fd_pc, fd_jump} = fd_valid ? ifq_head : 65'd0;

endmodule

// File: tb/tb_core_if.sv
// Bench for the fetch stage: in-order bus model with programmable latency, and a
// scoreboard of the architecturally expected instruction stream towards decode.
module tb_core_if;

   localparam int unsigned Depth   = 2;
   localparam logic [31:0] ResetPc = 32'h0000_0000;
   localparam logic [31:0] Nop     = 32'h0000_0013;
   localparam logic [31:0] Jal40   = 32'h0400_006F;
   localparam logic [31:0] BeqBack = 32'hFE00_0CE3;
   localparam logic [31:0] BeqFwd  = 32'h0000_0463;

   logic        clk = 1'b0;
   logic        rest = 1'b1;
   logic        ib_req_valid, ib_req_ready = 1'b1;
   logic [31:0] ib_req_addr;
   logic        ib_resp_valid = 1'b0;
   logic [31:0] ib_resp_data = '0;
   logic        ex_flush_en = 1'b0;
   logic [31:0] ex_flush_pc = '0;
   logic        fd_valid, fd_ready = 1'b0;
   logic [31:0] fd_istr, fd_pc;
   logic        fd_jump;

   core_if #(
      .RESET_PC  (ResetPc),
      .FIFO_DEPTH(Depth)
   ) dut (
      .clk          (clk),
      .rest         (rest),
      .ib_req_valid (ib_req_valid),
      .ib_req_ready (ib_req_ready),
      .ib_req_addr  (ib_req_addr),
      .ib_resp_valid(ib_resp_valid),
      .ib_resp_data (ib_resp_data),
      .ex_flush_en  (ex_flush_en),
      .ex_flush_pc  (ex_flush_pc),
      .fd_valid     (fd_valid),
      .fd_ready     (fd_ready),
      .fd_istr      (fd_istr),
      .fd_pc        (fd_pc),
      .fd_jump      (fd_jump)
   );

   always #5 clk = ~clk;

   typedef struct {logic [31:0] istr; logic [31:0] pc; logic jump;} exp_t;
   typedef struct {logic [31:0] addr; int due;} req_t;

   exp_t        sb[$];
   req_t        pend[$];
   logic [31:0] imem [logic [31:0]];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          lat = 1;
   bit          rdy_en = 1'b1;

   function automatic logic [31:0] fetch(input logic [31:0] a);
      if (imem.exists(a)) return imem[a];
      return Nop;
   endfunction

   // Architectural instruction stream from start, following predicted-taken control flow.
   function automatic void push_arch(input logic [31:0] start, input int n);
      logic [31:0] pc, d, tgt;
      logic        tk;
      exp_t        e;
      pc = start;
      for (int i = 0; i < n; i++) begin
         d   = fetch(pc);
         tk  = 1'b0;
         tgt = pc + 32'd4;
         if (d[6:0] == 7'h6F) begin
            tk  = 1'b1;
            tgt = pc + {{12{d[31]}}, d[19:12], d[20], d[30:21], 1'b0};
         end else if (d[6:0] == 7'h63 && d[31]) begin
            tk  = 1'b1;
            tgt = pc + {{20{d[31]}}, d[7], d[30:25], d[11:8], 1'b0};
         end
         e.istr = d;
         e.pc   = pc;
         e.jump = tk;
         sb.push_back(e);
         pc = tgt;
      end
   endfunction

   task automatic step();
      logic        req_fire, fd_fire, resp_fire;
      logic [31:0] addr;
      exp_t        e;
      req_t        r;
      fd_ready = rdy_en && (sb.size() > 0);
      #1;
      req_fire  = ib_req_valid && ib_req_ready;
      addr      = ib_req_addr;
      fd_fire   = fd_valid && fd_ready;
      resp_fire = ib_resp_valid;
      if (fd_fire) begin
         checks++;
         e = sb.pop_front();
         if ({fd_istr, fd_pc, fd_jump} !== {e.istr, e.pc, e.jump}) begin
            errors++;
            $display("FAIL deliver: got istr=%h pc=%h jump=%b, expected istr=%h pc=%h jump=%b",
                     fd_istr, fd_pc, fd_jump, e.istr, e.pc, e.jump);
         end
      end
      if (req_fire) begin
         checks++;
         if (addr[1:0] !== 2'b00 || pend.size() >= Depth) begin
            errors++;
            $display("FAIL credit: addr=%h outstanding=%0d, expected aligned and below %0d",
                     addr, pend.size(), Depth);
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      if (resp_fire && pend.size() > 0) pend.delete(0);
      if (rest) pend.delete();
      if (req_fire && !rest) begin
         r.addr = addr;
         r.due  = cyc + lat - 1;
         pend.push_back(r);
      end
      if (!rest && pend.size() > 0 && pend[0].due <= cyc) begin
         ib_resp_valid = 1'b1;
         ib_resp_data  = fetch(pend[0].addr);
      end else begin
         ib_resp_valid = 1'b0;
         ib_resp_data  = '0;
      end
   endtask

   task automatic run(input int budget);
      int n = 0;
      while (sb.size() > 0 && n < budget) begin
         step();
         n++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL timeout: %0d deliveries still pending, expected 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic do_reset();
      rest          = 1'b1;
      ex_flush_en   = 1'b0;
      ex_flush_pc   = '0;
      ib_resp_valid = 1'b0;
      ib_resp_data  = '0;
      rdy_en        = 1'b1;
      sb.delete();
      pend.delete();
      step();
      step();
      rest = 1'b0;
   endtask

   task automatic test_reset();
      imem.delete();
      lat  = 1;
      rest = 1'b1;
      step();
      step();
      checks++;
      if ({fd_valid, fd_istr, fd_pc, fd_jump, ib_req_valid} !== 67'd0) begin
         errors++;
         $display("FAIL reset_outputs: valid=%b istr=%h pc=%h jump=%b req=%b, expected all 0",
                  fd_valid, fd_istr, fd_pc, fd_jump, ib_req_valid);
      end
      rest = 1'b0;
      #1;
      checks++;
      if (ib_req_valid !== 1'b1 || ib_req_addr !== ResetPc) begin
         errors++;
         $display("FAIL reset_first_req: valid=%b addr=%h, expected 1 %h",
                  ib_req_valid, ib_req_addr, ResetPc);
      end
   endtask

   task automatic test_stream();
      do_reset();
      push_arch(32'h0, 8);
      run(100);
   endtask

   task automatic test_stall();
      do_reset();
      rdy_en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (fd_valid) begin
            checks++;
            if (fd_pc !== 32'h0 || fd_istr !== Nop || fd_jump !== 1'b0) begin
               errors++;
               $display("FAIL stall_hold: pc=%h istr=%h jump=%b, expected 0 %h 0",
                        fd_pc, fd_istr, fd_jump, Nop);
            end
         end
      end
      checks++;
      if (ib_req_valid !== 1'b0 || fd_valid !== 1'b1) begin
         errors++;
         $display("FAIL stall_credit: req_valid=%b fd_valid=%b, expected 0 1",
                  ib_req_valid, fd_valid);
      end
      rdy_en = 1'b1;
      push_arch(32'h0, 6);
      run(100);
   endtask

   task automatic test_flush();
      int n = 0;
      do_reset();
      lat = 3;
      while (pend.size() < 2 && n < 20) begin
         step();
         n++;
      end
      checks++;
      if (pend.size() != 2 || ib_resp_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_setup: outstanding=%0d resp=%b, expected 2 0",
                  pend.size(), ib_resp_valid);
      end
      ex_flush_en = 1'b1;
      ex_flush_pc = 32'h0000_0102;
      #1;
      checks++;
      if (ib_req_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_noreq: req_valid=%b, expected 0", ib_req_valid);
      end
      step();
      ex_flush_en = 1'b0;
      push_arch(32'h100, 4);
      run(100);
      lat = 1;
   endtask

   task automatic test_jal();
      do_reset();
      imem.delete();
      imem[32'h8] = Jal40;
      push_arch(32'h0, 6);
      run(100);
   endtask

   task automatic test_branch();
      do_reset();
      imem.delete();
      imem[32'h10] = BeqBack;
      push_arch(32'h0, 7);
      run(100);
      do_reset();
      imem[32'h10] = BeqFwd;
      push_arch(32'h0, 6);
      run(100);
   endtask

   task automatic test_flush_jal();
      int n = 0;
      do_reset();
      imem.delete();
      imem[32'h8] = Jal40;
      push_arch(32'h0, 2);
      while (!(ib_resp_valid && pend.size() > 0 && pend[0].addr == 32'h8) && n < 30) begin
         step();
         n++;
      end
      checks++;
      if (ib_resp_valid !== 1'b1 || sb.size() != 0) begin
         errors++;
         $display("FAIL flush_jal_setup: resp=%b pending=%0d, expected 1 0",
                  ib_resp_valid, sb.size());
      end
      ex_flush_en = 1'b1;
      ex_flush_pc = 32'h0000_0200;
      step();
      ex_flush_en = 1'b0;
      push_arch(32'h200, 3);
      run(100);
   endtask

   task automatic test_reset_mid();
      do_reset();
      rdy_en = 1'b0;
      for (int i = 0; i < 10; i++) step();
      checks++;
      if (fd_valid !== 1'b1 || fd_pc !== 32'h0) begin
         errors++;
         $display("FAIL midreset_full: fd_valid=%b pc=%h, expected 1 0", fd_valid, fd_pc);
      end
      rest = 1'b1;
      step();
      checks++;
      if (fd_valid !== 1'b0 || fd_pc !== 32'h0 || ib_req_valid !== 1'b0) begin
         errors++;
         $display("FAIL midreset_clear: fd_valid=%b pc=%h req=%b, expected 0 0 0",
                  fd_valid, fd_pc, ib_req_valid);
      end
      rest = 1'b0;
      #1;
      checks++;
      if (ib_req_valid !== 1'b1 || ib_req_addr !== ResetPc) begin
         errors++;
         $display("FAIL midreset_req: valid=%b addr=%h, expected 1 %h",
                  ib_req_valid, ib_req_addr, ResetPc);
      end
      rdy_en = 1'b1;
      push_arch(32'h0, 3);
      run(100);
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_flush();
      test_jal();
      test_branch();
      test_flush_jal();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
